stream2uart: RTL



---
 rtl/stream2uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/stream2uart.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stream2uart_pkg.sv
// ============================================================================
// Module      : stream2uart_pkg
// Description : Shared UART transmitter definitions: FSM state encoding,
//               data-bit count and common baud divisors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream2uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int c_DATA_BITS = 8;

    // Divisors at a 50 MHz system clock, kept for a future receiver.
    localparam int c_CLKS_115200_50MHZ = 434;
    localparam int c_CLKS_57600_50MHZ  = 868;
    localparam int c_CLKS_9600_50MHZ   = 5208;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter; pulses bit_done on the last cycle of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned c_CW = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_BIT - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_last;

    assign w_last   = (r_cnt == c_LAST);
    assign bit_done = w_last && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream2uart.sv
// ============================================================================
// Module      : stream2uart
// Description : AXI-Stream byte sink serialising each byte as a UART frame.
//               Define STREAM2UART_PARITY_EN to insert a parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream2uart
    import stream2uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic       tx,
    output logic       busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_idx_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        r_ready;
    logic        r_busy;
    logic        w_hs;
    logic        w_bit_done;
    logic        w_clear;

    assign w_hs     = s_tvalid && r_ready;
    assign w_clear  = (r_state == S_IDLE);
    assign s_tready = r_ready;
    assign tx       = r_tx;
    assign busy     = r_busy;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .bit_done (w_bit_done)
    );

`ifdef STREAM2UART_PARITY_EN
    logic r_parity;

    // Parity is taken from the byte as accepted, before shifting destroys it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_hs) begin
            r_parity <= (^s_tdata) ^ (PARITY_ODD != 0);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_bit_idx;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = s_tdata;
                    w_idx_nxt   = '0;
                end
            end
            S_START: begin
                if (w_bit_done) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_idx == 3'(c_DATA_BITS - 1)) begin
`ifdef STREAM2UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_bit_idx + 1'b1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef STREAM2UART_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    if (r_bit_idx == 3'(STOP_BITS - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_bit_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // tx is registered from the next state so the line changes with the state.
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef STREAM2UART_PARITY_EN
            S_PARITY: w_tx_nxt = r_parity;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

`default_nettype wire
